// File: rtl/phase_sequencer_arb.sv
// Runs the enabled list-maintenance engines in index order over the en/start/done protocol
// and routes the single-port node memory to whichever engine currently holds the grant.
module phase_sequencer_arb #(
    parameter  int N_ENG   = 4,
    parameter  int AW      = 11,
    parameter  int DW      = 16,
    parameter  int TIMEOUT = 4096,
    localparam int IW      = (N_ENG > 1) ? $clog2(N_ENG) : 1,
    localparam int CW      = $clog2(TIMEOUT) + 1
) (
    input  logic                clock,
    input  logic                nrst,
    input  logic                go,
    input  logic [N_ENG-1:0]    phase_mask,
    input  logic [N_ENG-1:0]    eng_done,
    input  logic [N_ENG*AW-1:0] eng_address,
    input  logic [N_ENG-1:0]    eng_wr_en,
    input  logic [N_ENG*DW-1:0] eng_data_out,
    input  logic [DW-1:0]       mem_data_in,
    output logic [N_ENG-1:0]    eng_en,
    output logic [N_ENG-1:0]    eng_start,
    output logic [DW-1:0]       eng_data_in,
    output logic [AW-1:0]       mem_address,
    output logic                mem_wr_en,
    output logic [DW-1:0]       mem_data_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [IW-1:0]       active_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_EN,
        S_START,
        S_WAIT,
        S_FIN
    } state_e;

    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [N_ENG-1:0] mask_q, mask_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    wd_q, wd_d;
    logic             error_q, error_d;
    logic [N_ENG-1:0] eng_en_q, eng_en_d;
    logic [N_ENG-1:0] eng_start_q, eng_start_d;
    logic [N_ENG-1:0] one_hot_d;
    logic             scan_found;
    logic [IW-1:0]    scan_idx;
    logic             grant;

    // Lowest pending engine at or above the current index; descending loop lets the lowest win.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                scan_found = 1'b1;
                scan_idx   = IW'(i);
            end
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        error_d = error_q;
        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (go) begin
                    mask_d  = phase_mask;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_found) begin
                    idx_d   = scan_idx;
                    state_d = S_EN;
                end else begin
                    idx_d   = '0;
                    state_d = S_FIN;
                end
            end
            S_EN:    state_d = S_START;
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done[idx_q]) begin
                    mask_d[idx_q] = 1'b0;
                    state_d       = S_SCAN;
                end else if (wd_q == WD_LIMIT) begin
                    error_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pulses are registered so they line up exactly with the EN / START state cycles.
        one_hot_d        = '0;
        one_hot_d[idx_d] = 1'b1;
        eng_en_d         = (state_d == S_EN)    ? one_hot_d : '0;
        eng_start_d      = (state_d == S_START) ? one_hot_d : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            error_q     <= 1'b0;
            eng_en_q    <= '0;
            eng_start_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            error_q     <= error_d;
            eng_en_q    <= eng_en_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign grant = (state_q == S_EN) || (state_q == S_START) || (state_q == S_WAIT);

    always_comb begin
        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
        if (grant) begin
            mem_address  = eng_address[int'(idx_q)*AW +: AW];
            mem_wr_en    = eng_wr_en[idx_q];
            mem_data_out = eng_data_out[int'(idx_q)*DW +: DW];
        end
    end

    assign eng_data_in = mem_data_in;
    assign eng_en      = eng_en_q;
    assign eng_start   = eng_start_q;
    assign busy        = (state_q == S_SCAN) || grant;
    assign done        = (state_q == S_FIN);
    assign error       = error_q;
    assign active_idx  = idx_q;

endmodule
